dsp_zender: RTL and testbench
=============================

# dsp_zender

DSP-side transmitter for the cry-volume link into the stress input stage. It accepts 8-bit cry-volume samples from the audio front end and buffers them in a small FIFO. It then presents each sample on `DSPingang` with a paced, single-cycle `DSPready` strobe that honours the setup, hold and gap times the stress input expects. It sits at the DSP end of the `DSPingang`/`DSPready` interface and is also used as the stimulus source in system-level benches of `totaal`.

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in samples; power of two, 2..16.
- `SETUP`, 2: cycles `DSPingang` is stable before `DSPready` rises; 1..255.
- `HOLD`, 2: cycles `DSPingang` stays stable after the strobe cycle; 0..255.
- `GAP`, 8: minimum idle cycles after HOLD before the next sample is loaded; 0..255.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `sampleValid`  in  1  push strobe from the audio front end.
- `sample`  in  8  cry-volume sample; captured when `sampleValid`=1.
- `DSPingang`  out  8  sample presented to the stress input.
- `DSPready`  out  1  one-cycle strobe; `DSPingang` is valid while it is high.
- `busy`  out  1  high in every state except IDLE, or while the FIFO is non-empty.
- `overflow`  out  1  sticky; set when a push is dropped; cleared only by `reset`.

## Operation
- Reset values: `DSPingang`=0, `DSPready`=0, `busy`=0, `overflow`=0, FIFO empty, state IDLE, pace counter 0.
- FIFO behaviour:
  - Push on `sampleValid`.
  - Push while full with no simultaneous pop: the sample is dropped, `overflow` is set, FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both take effect and `overflow` is not set.
  - Pop only from the FSM.
- FSM states: IDLE, SETUP, STROBE, HOLD, GAP.
  - IDLE: when the FIFO is non-empty, pop, register the head into `DSPingang`, load counter=SETUP-1 and go to SETUP.
  - SETUP: count down; at 0 go to STROBE.
  - STROBE: `DSPready`=1 for exactly this one cycle. If HOLD=0, go to GAP (or IDLE when GAP=0); otherwise load counter=HOLD-1 and go to HOLD.
  - HOLD: count down; at 0 go to GAP. If GAP=0, apply the GAP-exit rule directly.
  - GAP: count down, then exit. On exit, if the FIFO is non-empty, pop and load directly into SETUP (IDLE is skipped); otherwise go to IDLE.
- `DSPingang` changes only on a pop and holds its last value in IDLE. It is never zeroed except by reset.
- Counters are 8 bits and never wrap: a load is always ≥0 and the counter stops at 0.
- `DSPready` is registered and is never high for two consecutive cycles.
- Reset mid-transfer: all state clears asynchronously and `DSPready` falls immediately. A partially presented sample is lost without a strobe.

## Timing
- Push at edge 0 into an empty FIFO with the FSM in IDLE:
  - Edge 1: pop; `DSPingang` becomes valid.
  - `DSPready` is high from edge 1+SETUP to edge 2+SETUP (defaults: edges 3–4).
- Sample-to-strobe latency: SETUP+1 cycles from the push edge.
- Back-to-back throughput with the FIFO non-empty: one sample every SETUP+1+HOLD+GAP cycles (default 13).
- First sample after IDLE: one extra cycle (default period 14 measured from the push).
- `busy` is combinational from state and FIFO empty. All other outputs are registered.

## Structure
- Package `dsp_link_pkg` holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, GAP);
  - defaults `DSP_SETUP`=2, `DSP_HOLD`=2, `DSP_GAP`=8, `DSP_DEPTH`=4;
  - the sample width constant 8, shared with the stress input.
- Sub-module `zend_fifo` (parameter DEPTH, width 8):
  - registered storage, read/write pointers with an extra wrap bit, `full`/`empty` flags;
  - simultaneous push+pop is legal in every fill state, including full and empty.
- `dsp_zender` contains the pacing FSM, counter, output registers and overflow flag.

## Test plan
- Single sample 0x5A pushed at cycle 10 with defaults -> `DSPingang`=0x5A from cycle 11; `DSPready`=1 only in cycle 13; `busy` drops in cycle 24.
- Four samples 0x01..0x04 pushed on consecutive cycles -> four strobes at cycles s, s+13, s+26, s+39; data is in order and stable from 2 cycles before through 2 cycles after each strobe; `overflow`=0.
- Six consecutive pushes, DEPTH=4 -> one sample is popped after the first push, four fill the FIFO, and the sixth is dropped. Result: five strobes (0x01..0x05), and `overflow` is set on the edge after the sixth push.
- Push while full in the same cycle as a GAP-exit pop -> the sample is accepted, `overflow` stays 0, and all strobes arrive in order.
- `reset` asserted in the HOLD state mid-stream -> all outputs are 0 asynchronously; after release the FIFO is empty, with no further strobes until a new push.
- SETUP=1, HOLD=0, GAP=0 -> back-to-back strobes every 2 cycles and never high on adjacent cycles.

Source files
------------

// File: rtl/dsp_link_pkg.sv
// Shared definitions for the DSPingang/DSPready link: sample width, pacing
// defaults and the transmitter state encoding.
package dsp_link_pkg;

  localparam int SAMPLE_W = 8;

  localparam int DSP_SETUP = 2;
  localparam int DSP_HOLD  = 2;
  localparam int DSP_GAP   = 8;
  localparam int DSP_DEPTH = 4;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_GAP
  } zend_state_t;

  // Counter reload for an N-cycle phase; a zero-length phase reloads 0.
  function automatic logic [7:0] cnt_load(input int unsigned n);
    return (n == 0) ? 8'd0 : 8'(n - 1);
  endfunction

endpackage

// File: rtl/dsp_zender_if.sv
// Sample push port from the audio front end plus the paced output towards
// the stress input stage.
interface dsp_zender_if;
  import dsp_link_pkg::*;

  logic    sampleValid;
  sample_t sample;
  sample_t DSPingang;
  logic    DSPready;
  logic    busy;
  logic    overflow;

  modport master (
    output sampleValid,
    output sample,
    input  DSPingang,
    input  DSPready,
    input  busy,
    input  overflow
  );

  modport slave (
    input  sampleValid,
    input  sample,
    output DSPingang,
    output DSPready,
    output busy,
    output overflow
  );

endinterface

// File: rtl/zend_fifo.sv
// Sample FIFO with wrap-bit pointers; a pop frees its slot for a push in the
// same cycle, so push+pop is accepted even when full.
module zend_fifo
  import dsp_link_pkg::*;
#(
  parameter int DEPTH = DSP_DEPTH
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  sample_t wr_data,
  output sample_t rd_data,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  sample_t     mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dsp_zender.sv
// DSP-side transmitter: buffers cry-volume samples and presents each on
// DSPingang with a paced single-cycle DSPready strobe (setup/hold/gap).
module dsp_zender
  import dsp_link_pkg::*;
#(
  parameter int DEPTH = DSP_DEPTH,
  parameter int SETUP = DSP_SETUP,
  parameter int HOLD  = DSP_HOLD,
  parameter int GAP   = DSP_GAP
) (
  input logic         clk,
  input logic         reset,
  dsp_zender_if.slave link
);

  localparam logic [7:0] SETUP_LD = cnt_load(SETUP);
  localparam logic [7:0] HOLD_LD  = cnt_load(HOLD);
  localparam logic [7:0] GAP_LD   = cnt_load(GAP);
  localparam bit         HAS_HOLD = (HOLD != 0);
  localparam bit         HAS_GAP  = (GAP != 0);

  zend_state_t state;
  logic [7:0]  pace_cnt;
  sample_t     head;
  sample_t     ingang;
  logic        ready;
  logic        ovf;
  logic        full;
  logic        empty;
  logic        can_load;
  logic        pop;

  zend_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (link.sampleValid),
    .pop     (pop),
    .wr_data (link.sample),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // A new sample may be loaded from IDLE or at the end of the inter-sample
  // spacing; zero-length HOLD/GAP phases collapse that point onto an earlier state.
  always_comb begin
    can_load = 1'b0;
    case (state)
      ST_IDLE:   can_load = 1'b1;
      ST_STROBE: can_load = !HAS_HOLD && !HAS_GAP;
      ST_HOLD:   can_load = (pace_cnt == 8'd0) && !HAS_GAP;
      ST_GAP:    can_load = (pace_cnt == 8'd0);
      default:   can_load = 1'b0;
    endcase
  end

  assign pop = can_load && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      pace_cnt <= '0;
      ingang   <= '0;
      ready    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (pop) ingang <= head;
      if (link.sampleValid && full && !pop) ovf <= 1'b1;

      case (state)
        ST_SETUP: begin
          if (pace_cnt == 8'd0) begin
            state <= ST_STROBE;
            ready <= 1'b1;
          end else begin
            pace_cnt <= pace_cnt - 8'd1;
          end
        end

        ST_STROBE: begin
          if (HAS_HOLD) begin
            state    <= ST_HOLD;
            pace_cnt <= HOLD_LD;
          end else if (HAS_GAP) begin
            state    <= ST_GAP;
            pace_cnt <= GAP_LD;
          end else if (pop) begin
            state    <= ST_SETUP;
            pace_cnt <= SETUP_LD;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_HOLD: begin
          if (pace_cnt != 8'd0) begin
            pace_cnt <= pace_cnt - 8'd1;
          end else if (HAS_GAP) begin
            state    <= ST_GAP;
            pace_cnt <= GAP_LD;
          end else if (pop) begin
            state    <= ST_SETUP;
            pace_cnt <= SETUP_LD;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_GAP: begin
          if (pace_cnt != 8'd0) begin
            pace_cnt <= pace_cnt - 8'd1;
          end else if (pop) begin
            state    <= ST_SETUP;
            pace_cnt <= SETUP_LD;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: begin
          if (pop) begin
            state    <= ST_SETUP;
            pace_cnt <= SETUP_LD;
          end
        end
      endcase
    end
  end

  assign link.DSPingang = ingang;
  assign link.DSPready  = ready;
  assign link.overflow  = ovf;
  assign link.busy      = (state != ST_IDLE) || !empty;

endmodule

// File: tb/tb_dsp_zender.sv
// Bench for dsp_zender: a default-timed instance and a SETUP=1/HOLD=0/GAP=0
// instance, both checked against a queue-and-schedule reference model.
module tb_dsp_zender;
  import dsp_link_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dsp_zender_if a_if ();
  dsp_zender_if b_if ();

  dsp_zender #(.DEPTH(4), .SETUP(2), .HOLD(2), .GAP(8)) dut_a (
    .clk(clk), .reset(reset), .link(a_if)
  );
  dsp_zender #(.DEPTH(4), .SETUP(1), .HOLD(0), .GAP(0)) dut_b (
    .clk(clk), .reset(reset), .link(b_if)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // Reference model: per instance a FIFO image plus the earliest edge at which
  // the next sample may be loaded (last load + SETUP+1+HOLD+GAP).
  int         cfg_s [2] = '{2, 1};
  int         cfg_h [2] = '{2, 0};
  int         cfg_g [2] = '{8, 0};
  logic [7:0] m_mem [2][4];
  int         m_cnt [2];
  int         m_tfree [2];
  int         m_lastpop [2];
  logic [7:0] m_ingang [2];
  logic       m_ready [2];
  logic       m_busy [2];
  logic       m_ovf [2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d]     = 0;
      m_tfree[d]   = 0;
      m_lastpop[d] = -1000;
      m_ingang[d]  = 8'h00;
      m_ready[d]   = 1'b0;
      m_busy[d]    = 1'b0;
      m_ovf[d]     = 1'b0;
    end
  endfunction

  function automatic void model_edge(int d, logic valid, logic [7:0] data);
    logic pop;
    pop = (m_cnt[d] > 0) && (edge_n >= m_tfree[d]);
    m_ready[d] = (edge_n == m_lastpop[d] + cfg_s[d]);
    if (pop) begin
      m_ingang[d] = m_mem[d][0];
      for (int i = 0; i < 3; i++) m_mem[d][i] = m_mem[d][i+1];
      m_cnt[d]--;
      m_lastpop[d] = edge_n;
      m_tfree[d]   = edge_n + cfg_s[d] + 1 + cfg_h[d] + cfg_g[d];
    end
    if (valid) begin
      if (m_cnt[d] < 4) begin
        m_mem[d][m_cnt[d]] = data;
        m_cnt[d]++;
      end else begin
        m_ovf[d] = 1'b1;
      end
    end
    m_busy[d] = (m_cnt[d] > 0) || (edge_n < m_tfree[d]);
  endfunction

  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (reset) begin
      model_reset();
    end else begin
      model_edge(0, a_if.sampleValid, a_if.sample);
      model_edge(1, b_if.sampleValid, b_if.sample);
    end
    #1;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while ((a_if.busy || b_if.busy) && i < 300) begin
      tick();
      i++;
    end
    n_assert++;
    if (a_if.busy || b_if.busy) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy a=%b b=%b, required 0 within 300 cycles", name, a_if.busy, b_if.busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_if.sampleValid = 1'b0; a_if.sample = 8'h00;
    b_if.sampleValid = 1'b0; b_if.sample = 8'h00;
    model_reset();
    repeat (3) tick();
    n_assert++; if (a_if.DSPingang !== 8'h00) begin n_fail++; $display("FAIL reset_ingang: got %h required 00", a_if.DSPingang); end
    n_assert++; if (a_if.DSPready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", a_if.DSPready); end
    n_assert++; if (a_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", a_if.busy); end
    n_assert++; if (a_if.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b required 0", a_if.overflow); end
    reset = 1'b0;
    repeat (2) tick();
    n_assert++; if (a_if.busy !== 1'b0 || b_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got a=%b b=%b required 0", a_if.busy, b_if.busy); end
  endtask

  task automatic test_single();
    int p;
    int strobe_edge;
    int busy_drop;
    strobe_edge = -1;
    busy_drop   = -1;
    wait_idle("single");
    a_if.sampleValid = 1'b1; a_if.sample = 8'h5A;
    tick();
    p = edge_n;
    a_if.sampleValid = 1'b0;
    n_assert++; if (a_if.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_on_push: got %b required 1", a_if.busy); end
    for (int i = 1; i < 20; i++) begin
      tick();
      n_assert++; if (a_if.DSPingang !== m_ingang[0]) begin n_fail++; $display("FAIL single_ingang @%0d: got %h required %h", i, a_if.DSPingang, m_ingang[0]); end
      n_assert++; if (a_if.DSPready !== m_ready[0]) begin n_fail++; $display("FAIL single_ready @%0d: got %b required %b", i, a_if.DSPready, m_ready[0]); end
      if (a_if.DSPready === 1'b1 && strobe_edge < 0) strobe_edge = edge_n;
      if (a_if.busy === 1'b0 && busy_drop < 0) busy_drop = edge_n;
    end
    n_assert++; if (strobe_edge != p + 3) begin n_fail++; $display("FAIL single_strobe_time: got %0d required %0d", strobe_edge - p, 3); end
    n_assert++; if (busy_drop != p + 14) begin n_fail++; $display("FAIL single_busy_drop: got %0d required %0d", busy_drop - p, 14); end
  endtask

  task automatic test_burst();
    int p;
    int se[$];
    logic [7:0] sd[$];
    wait_idle("burst");
    p = edge_n + 1;
    for (int i = 0; i < 60; i++) begin
      a_if.sampleValid = (i < 4);
      a_if.sample      = 8'(i + 1);
      tick();
      n_assert++; if (a_if.DSPingang !== m_ingang[0]) begin n_fail++; $display("FAIL burst_ingang @%0d: got %h required %h", i, a_if.DSPingang, m_ingang[0]); end
      n_assert++; if (a_if.DSPready !== m_ready[0]) begin n_fail++; $display("FAIL burst_ready @%0d: got %b required %b", i, a_if.DSPready, m_ready[0]); end
      if (a_if.DSPready === 1'b1) begin se.push_back(edge_n); sd.push_back(a_if.DSPingang); end
    end
    a_if.sampleValid = 1'b0;
    n_assert++; if (se.size() != 4) begin n_fail++; $display("FAIL burst_count: got %0d required 4", se.size()); end
    for (int k = 0; k < se.size() && k < 4; k++) begin
      n_assert++; if (se[k] != p + 3 + 13 * k) begin n_fail++; $display("FAIL burst_time[%0d]: got %0d required %0d", k, se[k] - p, 3 + 13 * k); end
      n_assert++; if (sd[k] !== 8'(k + 1)) begin n_fail++; $display("FAIL burst_data[%0d]: got %h required %h", k, sd[k], 8'(k + 1)); end
    end
    n_assert++; if (a_if.overflow !== 1'b0) begin n_fail++; $display("FAIL burst_overflow: got %b required 0", a_if.overflow); end
  endtask

  task automatic test_full_pop();
    logic [7:0] expd [6] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h66};
    logic [7:0] sd[$];
    wait_idle("full_pop");
    for (int i = 0; i < 85; i++) begin
      a_if.sampleValid = (i < 5) || (i == 14);
      a_if.sample      = (i < 5) ? 8'(8'h11 + i) : 8'h66;
      tick();
      n_assert++; if (a_if.DSPready !== m_ready[0]) begin n_fail++; $display("FAIL fullpop_ready @%0d: got %b required %b", i, a_if.DSPready, m_ready[0]); end
      n_assert++; if (a_if.DSPingang !== m_ingang[0]) begin n_fail++; $display("FAIL fullpop_ingang @%0d: got %h required %h", i, a_if.DSPingang, m_ingang[0]); end
      if (i == 14) begin
        n_assert++; if (a_if.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_overflow_at_push: got %b required 0", a_if.overflow); end
      end
      if (a_if.DSPready === 1'b1) sd.push_back(a_if.DSPingang);
    end
    a_if.sampleValid = 1'b0;
    n_assert++; if (sd.size() != 6) begin n_fail++; $display("FAIL fullpop_count: got %0d required 6", sd.size()); end
    for (int k = 0; k < sd.size() && k < 6; k++) begin
      n_assert++; if (sd[k] !== expd[k]) begin n_fail++; $display("FAIL fullpop_data[%0d]: got %h required %h", k, sd[k], expd[k]); end
    end
    n_assert++; if (a_if.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_overflow_end: got %b required 0", a_if.overflow); end
  endtask

  task automatic test_overflow();
    logic [7:0] sd[$];
    wait_idle("overflow");
    for (int i = 0; i < 70; i++) begin
      a_if.sampleValid = (i < 6);
      a_if.sample      = 8'(i + 1);
      tick();
      if (i < 6) begin
        n_assert++; if (a_if.overflow !== (i == 5)) begin n_fail++; $display("FAIL overflow_flag @push%0d: got %b required %b", i + 1, a_if.overflow, (i == 5)); end
      end
      n_assert++; if (a_if.DSPready !== m_ready[0]) begin n_fail++; $display("FAIL overflow_ready @%0d: got %b required %b", i, a_if.DSPready, m_ready[0]); end
      if (a_if.DSPready === 1'b1) sd.push_back(a_if.DSPingang);
    end
    a_if.sampleValid = 1'b0;
    n_assert++; if (sd.size() != 5) begin n_fail++; $display("FAIL overflow_count: got %0d required 5", sd.size()); end
    for (int k = 0; k < sd.size() && k < 5; k++) begin
      n_assert++; if (sd[k] !== 8'(k + 1)) begin n_fail++; $display("FAIL overflow_data[%0d]: got %h required %h", k, sd[k], 8'(k + 1)); end
    end
    n_assert++; if (a_if.overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b required 1", a_if.overflow); end
  endtask

  task automatic test_midreset();
    bit found;
    int p;
    int se;
    wait_idle("midreset");
    a_if.sampleValid = 1'b1; a_if.sample = 8'h31; tick();
    a_if.sample = 8'h32; tick();
    a_if.sampleValid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (a_if.DSPready === 1'b1) found = 1'b1;
    end
    n_assert++; if (!found) begin n_fail++; $display("FAIL midreset_strobe_timeout: got no strobe, required one within 20 cycles"); end
    tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_assert++; if (a_if.DSPingang !== 8'h00) begin n_fail++; $display("FAIL midreset_ingang: got %h required 00", a_if.DSPingang); end
    n_assert++; if (a_if.DSPready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b required 0", a_if.DSPready); end
    n_assert++; if (a_if.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b required 0", a_if.busy); end
    n_assert++; if (a_if.overflow !== 1'b0) begin n_fail++; $display("FAIL midreset_overflow: got %b required 0", a_if.overflow); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_assert++; if (a_if.DSPready !== 1'b0 || a_if.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_quiet @%0d: got ready=%b busy=%b required 0/0", i, a_if.DSPready, a_if.busy); end
    end
    a_if.sampleValid = 1'b1; a_if.sample = 8'h44;
    tick();
    p = edge_n;
    a_if.sampleValid = 1'b0;
    se = -1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_if.DSPready === 1'b1 && se < 0) begin
        se = edge_n;
        n_assert++; if (a_if.DSPingang !== 8'h44) begin n_fail++; $display("FAIL midreset_new_data: got %h required 44", a_if.DSPingang); end
      end
    end
    n_assert++; if (se != p + 3) begin n_fail++; $display("FAIL midreset_new_strobe: got %0d required 3", se - p); end
  endtask

  task automatic test_random();
    wait_idle("random");
    for (int i = 0; i < 400; i++) begin
      a_if.sampleValid = ($urandom_range(0, 9) == 0);
      a_if.sample      = 8'($urandom);
      b_if.sampleValid = ($urandom_range(0, 2) == 0);
      b_if.sample      = 8'($urandom);
      tick();
      n_assert++; if (a_if.DSPingang !== m_ingang[0]) begin n_fail++; $display("FAIL rand_a_ingang @%0d: got %h required %h", i, a_if.DSPingang, m_ingang[0]); end
      n_assert++; if (a_if.DSPready !== m_ready[0]) begin n_fail++; $display("FAIL rand_a_ready @%0d: got %b required %b", i, a_if.DSPready, m_ready[0]); end
      n_assert++; if (a_if.busy !== m_busy[0]) begin n_fail++; $display("FAIL rand_a_busy @%0d: got %b required %b", i, a_if.busy, m_busy[0]); end
      n_assert++; if (a_if.overflow !== m_ovf[0]) begin n_fail++; $display("FAIL rand_a_overflow @%0d: got %b required %b", i, a_if.overflow, m_ovf[0]); end
      n_assert++; if (b_if.DSPingang !== m_ingang[1]) begin n_fail++; $display("FAIL rand_b_ingang @%0d: got %h required %h", i, b_if.DSPingang, m_ingang[1]); end
      n_assert++; if (b_if.DSPready !== m_ready[1]) begin n_fail++; $display("FAIL rand_b_ready @%0d: got %b required %b", i, b_if.DSPready, m_ready[1]); end
      n_assert++; if (b_if.busy !== m_busy[1]) begin n_fail++; $display("FAIL rand_b_busy @%0d: got %b required %b", i, b_if.busy, m_busy[1]); end
      n_assert++; if (b_if.overflow !== m_ovf[1]) begin n_fail++; $display("FAIL rand_b_overflow @%0d: got %b required %b", i, b_if.overflow, m_ovf[1]); end
    end
    a_if.sampleValid = 1'b0;
    b_if.sampleValid = 1'b0;
  endtask

  task automatic test_fast();
    int se[$];
    logic [7:0] sd[$];
    logic prev;
    wait_idle("fast");
    prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      b_if.sampleValid = (i < 5);
      b_if.sample      = 8'(8'hA1 + i);
      tick();
      n_assert++; if (b_if.DSPready !== m_ready[1]) begin n_fail++; $display("FAIL fast_ready @%0d: got %b required %b", i, b_if.DSPready, m_ready[1]); end
      n_assert++; if (prev === 1'b1 && b_if.DSPready === 1'b1) begin n_fail++; $display("FAIL fast_adjacent @%0d: got ready high twice required single cycle", i); end
      prev = b_if.DSPready;
      if (b_if.DSPready === 1'b1) begin se.push_back(edge_n); sd.push_back(b_if.DSPingang); end
    end
    b_if.sampleValid = 1'b0;
    n_assert++; if (se.size() != 5) begin n_fail++; $display("FAIL fast_count: got %0d required 5", se.size()); end
    for (int k = 0; k < se.size() && k < 5; k++) begin
      n_assert++; if (sd[k] !== 8'(8'hA1 + k)) begin n_fail++; $display("FAIL fast_data[%0d]: got %h required %h", k, sd[k], 8'(8'hA1 + k)); end
      if (k > 0) begin
        n_assert++; if (se[k] - se[k-1] != 2) begin n_fail++; $display("FAIL fast_period[%0d]: got %0d required 2", k, se[k] - se[k-1]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_pop();
    test_overflow();
    test_midreset();
    test_random();
    test_fast();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
